motor_hbridge_seq: RTL and testbench

Sequential drive stage between the awning decision logic and the H-bridge motor driver IC. It takes the combinational close/open requests (A, B) and the limit switches (Fe, Fd), and produces the bridge inputs IN1/IN2. It enforces a dead time on every stop and reversal, and a hard stop at the active limit switch. A run-time watchdog latches a fault if the motor runs too long.

---
 rtl/motor_hbridge_seq.sv | 166 ++++++++++++++++
 tb/tb_motor_hbridge_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/motor_hbridge_seq.sv
// motor_hbridge_seq
//
// Sequential drive stage feeding an H-bridge driver IC. The close/open
// requests and the two limit switches are synchronized, qualified and fed
// to a Moore FSM that drives the bridge inputs. Every stop and reversal
// passes through a dead-time state, and a run-time watchdog latches a
// fault when the motor runs for TIMEOUT_CYC cycles without stopping.
//
// Parameters
//   DEAD_CYC     cycles both bridge inputs stay low after a run ends (>= 1)
//   TIMEOUT_CYC  maximum continuous run length in cycles (>= 2)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   A      in   close request (anti-clockwise), asynchronous
//   B      in   open request (clockwise), asynchronous
//   Fe     in   left limit switch, 1 = fully closed, asynchronous
//   Fd     in   right limit switch, 1 = fully open, asynchronous
//   clr    in   fault clear, synchronous, only honoured in FAULT
//   IN1    out  bridge input, 1 = drive close
//   IN2    out  bridge input, 1 = drive open
//   fault  out  watchdog fault flag
module motor_hbridge_seq #(
   parameter int DEAD_CYC    = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A,
   input  logic B,
   input  logic Fe,
   input  logic Fd,
   input  logic clr,
   output logic IN1,
   output logic IN2,
   output logic fault
);

   localparam int RUN_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int DEAD_W = $clog2(DEAD_CYC + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(TIMEOUT_CYC);
   localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_CLOSE,
      S_RUN_OPEN,
      S_DEAD,
      S_FAULT
   } state_t;

   // Saturating increment: the run counter never wraps.
   function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
      return (v == RUN_MAX) ? v : v + RUN_W'(1);
   endfunction

   // Packed as {Fd, Fe, B, A}
   logic [3:0]        sync_p0;
   logic [3:0]        sync_p1;
   logic              sa, sb, sfe, sfd;
   logic              req_close, req_open;
   state_t            state, state_nxt;
   logic [RUN_W-1:0]  run_cnt, run_cnt_nxt, run_cnt_inc;
   logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;

   // ---- Stage p0 -> p1: two-flop synchronizers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= {Fd, Fe, B, A};
         sync_p1 <= sync_p0;
      end
   end

   assign sa  = sync_p1[0];
   assign sb  = sync_p1[1];
   assign sfe = sync_p1[2];
   assign sfd = sync_p1[3];

   // A=B=1 cancels both requests; an active limit switch blocks its direction.
   assign req_close = sa & ~sb & ~sfe;
   assign req_open  = sb & ~sa & ~sfd;

   // run_cnt holds the number of RUN cycles already completed, so the
   // incremented value equals the length of the cycle now ending. Reaching
   // TIMEOUT_CYC here means the motor has been driven exactly that long.
   assign run_cnt_inc = sat_inc(run_cnt);

   // ---- Stage p1 -> state: next-state decision ----
   always_comb begin
      state_nxt    = state;
      run_cnt_nxt  = run_cnt;
      dead_cnt_nxt = dead_cnt;
      case (state)
         S_IDLE: begin
            if (req_close) begin
               state_nxt   = S_RUN_CLOSE;
               run_cnt_nxt = '0;
            end else if (req_open) begin
               state_nxt   = S_RUN_OPEN;
               run_cnt_nxt = '0;
            end
         end
         S_RUN_CLOSE: begin
            // Request loss wins over timeout on the same edge.
            if (!req_close) begin
               state_nxt    = S_DEAD;
               dead_cnt_nxt = DEAD_LOAD;
            end else if (run_cnt_inc == RUN_MAX) begin
               state_nxt = S_FAULT;
            end else begin
               run_cnt_nxt = run_cnt_inc;
            end
         end
         S_RUN_OPEN: begin
            if (!req_open) begin
               state_nxt    = S_DEAD;
               dead_cnt_nxt = DEAD_LOAD;
            end else if (run_cnt_inc == RUN_MAX) begin
               state_nxt = S_FAULT;
            end else begin
               run_cnt_nxt = run_cnt_inc;
            end
         end
         S_DEAD: begin
            if (dead_cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               dead_cnt_nxt = dead_cnt - DEAD_W'(1);
            end
         end
         S_FAULT: begin
            if (clr) begin
               state_nxt    = S_DEAD;
               dead_cnt_nxt = DEAD_LOAD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- State register with registered Moore outputs ----
   // Outputs are flops loaded from the next-state decode, so they always
   // equal the state decode and cannot glitch; reset clears them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         run_cnt  <= '0;
         dead_cnt <= '0;
         IN1      <= 1'b0;
         IN2      <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_nxt;
         run_cnt  <= run_cnt_nxt;
         dead_cnt <= dead_cnt_nxt;
         IN1      <= (state_nxt == S_RUN_CLOSE);
         IN2      <= (state_nxt == S_RUN_OPEN);
         fault    <= (state_nxt == S_FAULT);
      end
   end

endmodule

// File: tb/tb_motor_hbridge_seq.sv
// Testbench for motor_hbridge_seq (DEAD_CYC=4, TIMEOUT_CYC=20).
// A behavioural model tracks drive direction, run length, remaining off
// time and fault; one process compares the DUT against it every cycle.
// Directed scenarios add literal expectations; a random phase follows.
module tb_motor_hbridge_seq;

   localparam int DEAD = 4;
   localparam int TMO  = 20;

   logic clk, rst_n, A, B, Fe, Fd, clr;
   logic IN1, IN2, fault;

   int checks = 0;
   int errors = 0;

   motor_hbridge_seq #(.DEAD_CYC(DEAD), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Fe(Fe), .Fd(Fd), .clr(clr),
      .IN1(IN1), .IN2(IN2), .fault(fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_drive: 0 none, 1 closing, 2 opening. m_run: cycles driven so far.
   // m_off: off-time cycles still owed before a new run may be considered.
   int       m_drive = 0;
   int       m_run   = 0;
   int       m_off   = 0;
   bit       m_fault = 1'b0;
   logic [3:0] h1 = '0;   // {Fd,Fe,B,A} captured one edge ago
   logic [3:0] h2 = '0;   // captured two edges ago: what the FSM acts on

   task automatic model_reset();
      m_drive = 0; m_run = 0; m_off = 0; m_fault = 1'b0;
      h1 = '0; h2 = '0;
   endtask

   task automatic model_step();
      logic [3:0] s;
      bit rc, ro, keep;
      s  = h2;
      h2 = h1;
      h1 = {Fd, Fe, B, A};
      rc = s[0] && !s[1] && !s[2];
      ro = s[1] && !s[0] && !s[3];
      if (m_fault) begin
         if (clr) begin
            m_fault = 1'b0;
            m_off   = DEAD;
         end
      end else if (m_off > 0) begin
         m_off--;
      end else if (m_drive == 0) begin
         if (rc) begin m_drive = 1; m_run = 1; end
         else if (ro) begin m_drive = 2; m_run = 1; end
      end else begin
         keep = (m_drive == 1) ? rc : ro;
         if (!keep) begin
            m_drive = 0; m_off = DEAD;
         end else if (m_run == TMO) begin
            m_drive = 0; m_fault = 1'b1;
         end else begin
            m_run++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("cmp_in1",   int'(IN1),   int'(m_drive == 1));
         check("cmp_in2",   int'(IN2),   int'(m_drive == 2));
         check("cmp_fault", int'(fault), int'(m_fault));
         check("cmp_excl",  int'(IN1 & IN2), 0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, m, r;
      rst_n = 1'b0; A = 1'b1; B = 1'b0; Fe = 1'b0; Fd = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in1",   int'(IN1),   0);
      check("reset_in2",   int'(IN2),   0);
      check("reset_fault", int'(fault), 0);

      // Close run: A already high; first edge after release is edge 0.
      rst_n = 1'b1;
      @(negedge clk);                       // after edge 0
      @(negedge clk);                       // after edge 1
      check("close_e1", int'(IN1), 0);
      @(negedge clk);                       // after edge 2
      check("close_e2", int'(IN1), 1);
      check("model_pin_close", m_drive, 1);
      repeat (7) @(negedge clk);            // after edge 9
      Fe = 1'b1;
      @(negedge clk); check("fe_e10", int'(IN1), 1);
      @(negedge clk); check("fe_e11", int'(IN1), 1);
      @(negedge clk); check("fe_e12", int'(IN1), 0);
      check("model_pin_dead", m_off, DEAD);
      n = 0;
      repeat (20) begin @(negedge clk); n += int'(IN1); end
      check("fe_hold_no_run", n, 0);

      // Reversal
      Fe = 1'b0;
      n = 0;
      while (IN1 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("rev_start", int'(IN1), 1);
      A = 1'b0; B = 1'b1;
      n = 0; m = 0;
      while (IN2 !== 1'b1 && m < 40) begin
         @(negedge clk); m++;
         if (!IN1 && !IN2) n++;
      end
      check("rev_gap", n, DEAD + 1);

      // Watchdog: IN2 is high on this cycle, B held
      n = 0;
      while (IN2 === 1'b1 && n < 40) begin n++; @(negedge clk); end
      check("wd_run_len", n, TMO);
      check("wd_fault",   int'(fault), 1);
      check("wd_in2_off", int'(IN2), 0);
      repeat (12) begin B = 1'($urandom_range(1)); @(negedge clk); end
      check("wd_fault_hold", int'(fault), 1);
      B = 1'b1; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_fault_drop", int'(fault), 0);
      n = 0; m = 0;
      while (IN2 !== 1'b1 && m < 40) begin n++; @(negedge clk); m++; end
      check("clr_gap", n, DEAD + 1);

      // Illegal input combinations
      B = 1'b0;
      repeat (12) @(negedge clk);
      A = 1'b1; B = 1'b1;
      n = 0;
      repeat (15) begin @(negedge clk); n += int'(IN1 | IN2); end
      check("ab_no_run", n, 0);
      check("ab_no_fault", int'(fault), 0);
      B = 1'b0; Fe = 1'b1; Fd = 1'b1;
      n = 0;
      repeat (15) begin @(negedge clk); n += int'(IN1 | IN2); end
      check("fefd_no_run", n, 0);
      check("fefd_no_fault", int'(fault), 0);
      A = 1'b0; Fe = 1'b0; Fd = 1'b0;
      repeat (8) @(negedge clk);

      // Asynchronous reset mid-run
      B = 1'b1;
      n = 0;
      while (IN2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("arst_pre", int'(IN2), 1);
      #2 rst_n = 1'b0;
      #1 check("arst_in2", int'(IN2), 0);
      check("arst_fault", int'(fault), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Random phase: slowly changing inputs so runs, stops and timeouts occur
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(15) == 0) begin
            r = int'($urandom_range(3));
            A = r[0]; B = r[1];
         end
         if ($urandom_range(31) == 0) Fe = ($urandom_range(3) == 0);
         if ($urandom_range(31) == 0) Fd = ($urandom_range(3) == 0);
         clr = ($urandom_range(7) == 0);
         if (i == 1500) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      A = 1'b0; B = 1'b0; Fe = 1'b0; Fd = 1'b0; clr = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
